// File: rtl/regression_pkg.sv
// Shared types and frame layout for the regression result transmitter.
// frame_byte() assembles any of the seven frame bytes from the per-field digit records.
package regression_pkg;

  localparam int FRAME_LEN = 7;

  localparam logic [1:0] FIELD_DET    = 2'b00;
  localparam logic [1:0] FIELD_B      = 2'b01;
  localparam logic [1:0] FIELD_SLOPE  = 2'b10;
  localparam logic [1:0] FIELD_STATUS = 2'b11;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} tx_state_t;

  typedef struct packed {
    logic       sign;
    logic       ovf;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_field_t;

  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input bcd_field_t d,
                                            input bcd_field_t b, input bcd_field_t s,
                                            input logic err);
    logic [7:0] byte_val;
    case (idx)
      3'd0:    byte_val = {FIELD_DET,   d.sign, 1'b1, d.tens};
      3'd1:    byte_val = {FIELD_DET,   d.sign, 1'b0, d.ones};
      3'd2:    byte_val = {FIELD_B,     b.sign, 1'b1, b.tens};
      3'd3:    byte_val = {FIELD_B,     b.sign, 1'b0, b.ones};
      3'd4:    byte_val = {FIELD_SLOPE, s.sign, 1'b1, s.tens};
      3'd5:    byte_val = {FIELD_SLOPE, s.sign, 1'b0, s.ones};
      default: byte_val = {FIELD_STATUS, 2'b00, err, d.ovf, b.ovf, s.ovf};
    endcase
    return byte_val;
  endfunction

endpackage

// File: rtl/bcd2_sat.sv
// Signed value to sign + two BCD digits, saturating at 99.
// The tens digit comes from a restoring compare/subtract chain, so no divider is built.
module bcd2_sat #(
  parameter int RESULT_WIDTH = 32
) (
  input  logic [RESULT_WIDTH-1:0] value,
  output logic                    sign,
  output logic                    ovf,
  output logic [3:0]              tens,
  output logic [3:0]              ones
);

  logic [RESULT_WIDTH-1:0] mag;
  logic [6:0]              rem;

  // The most-negative input negates to itself, which still compares above 99.
  always_comb begin
    sign = value[RESULT_WIDTH-1];
    mag  = sign ? (~value + RESULT_WIDTH'(1)) : value;
    ovf  = (mag > RESULT_WIDTH'(99));
    rem  = ovf ? 7'd99 : mag[6:0];
    tens = 4'd0;
    if (rem >= 7'd80) begin tens[3] = 1'b1; rem = rem - 7'd80; end
    if (rem >= 7'd40) begin tens[2] = 1'b1; rem = rem - 7'd40; end
    if (rem >= 7'd20) begin tens[1] = 1'b1; rem = rem - 7'd20; end
    if (rem >= 7'd10) begin tens[0] = 1'b1; rem = rem - 7'd10; end
    ones = rem[3:0];
  end

endmodule

// File: rtl/regression_result_tx.sv
// Captures one regression result on start and streams it as a 7-byte BCD frame
// over a valid/ready byte interface.
module regression_result_tx
  import regression_pkg::*;
#(
  parameter int RESULT_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [RESULT_WIDTH-1:0] det,
  input  logic [RESULT_WIDTH-1:0] intercept,
  input  logic [RESULT_WIDTH-1:0] slope,
  input  logic                    error_det,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [7:0]              out_data,
  output logic                    busy,
  output logic                    done,
  output logic [7:0]              frame_cnt
);

  tx_state_t               state;
  logic [RESULT_WIDTH-1:0] det_q, b_q, slope_q;
  logic                    err_q;
  logic [2:0]              idx;
  bcd_field_t              det_live, b_raw, slope_raw, b_live, slope_live;
  bcd_field_t              det_r, b_r, slope_r;

  bcd2_sat #(.RESULT_WIDTH(RESULT_WIDTH)) u_det (
    .value(det_q), .sign(det_live.sign), .ovf(det_live.ovf),
    .tens(det_live.tens), .ones(det_live.ones));
  bcd2_sat #(.RESULT_WIDTH(RESULT_WIDTH)) u_b (
    .value(b_q), .sign(b_raw.sign), .ovf(b_raw.ovf),
    .tens(b_raw.tens), .ones(b_raw.ones));
  bcd2_sat #(.RESULT_WIDTH(RESULT_WIDTH)) u_slope (
    .value(slope_q), .sign(slope_raw.sign), .ovf(slope_raw.ovf),
    .tens(slope_raw.tens), .ones(slope_raw.ones));

  // A singular matrix makes b and slope meaningless, so they are sent as a clean zero.
  assign b_live     = err_q ? '0 : b_raw;
  assign slope_live = err_q ? '0 : slope_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      det_q     <= '0;
      b_q       <= '0;
      slope_q   <= '0;
      err_q     <= 1'b0;
      det_r     <= '0;
      b_r       <= '0;
      slope_r   <= '0;
      idx       <= 3'd0;
      out_valid <= 1'b0;
      out_data  <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            det_q   <= det;
            b_q     <= intercept;
            slope_q <= slope;
            err_q   <= error_det;
            busy    <= 1'b1;
            state   <= LOAD;
          end
        end
        // Byte 0 is built from the live converter outputs so it appears without a bubble.
        LOAD: begin
          det_r     <= det_live;
          b_r       <= b_live;
          slope_r   <= slope_live;
          idx       <= 3'd0;
          out_data  <= frame_byte(3'd0, det_live, b_live, slope_live, err_q);
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (out_valid && out_ready) begin
            if (idx == 3'(FRAME_LEN - 1)) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              frame_cnt <= frame_cnt + 8'd1;
              state     <= DONE;
            end else begin
              idx      <= idx + 3'd1;
              out_data <= frame_byte(idx + 3'd1, det_r, b_r, slope_r, err_q);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regression_result_tx.sv
// Self-checking bench for regression_result_tx: table of frames with hand-computed bytes,
// plus backpressure, start-while-busy, reset mid-frame and frame counter wrap sequences.
module tb_regression_result_tx;

  logic        clk = 1'b0;
  logic        rst, start, error_det, out_ready;
  logic [31:0] det, intercept, slope;
  logic        out_valid, busy, done;
  logic [7:0]  out_data, frame_cnt;

  always #5 clk = ~clk;

  regression_result_tx #(.RESULT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .det(det), .intercept(intercept),
    .slope(slope), .error_det(error_det), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .busy(busy), .done(done),
    .frame_cnt(frame_cnt)
  );

  typedef struct {
    string       name;
    logic [31:0] det;
    logic [31:0] b;
    logic [31:0] slope;
    logic        err;
    logic [55:0] exp;
  } vec_t;

  vec_t       vecs[6];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_cnt;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one vector's inputs with a single-cycle start; returns at the following negedge.
  task automatic applyStimulus(input int v);
    det       = vecs[v].det;
    intercept = vecs[v].b;
    slope     = vecs[v].slope;
    error_det = vecs[v].err;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic send_frame(input int v, input int stall_at, input int stall_len,
                            input bit poke_busy);
    int         i = 0;
    int         cyc = 1;
    int         stalled = 0;
    bit         poked = 0;
    logic [7:0] exp_b;
    applyStimulus(v);
    checkOutput({vecs[v].name, "/valid_in_load"}, 32'(out_valid), 32'd0);
    while (i < 7 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (poke_busy && i == 2 && !poked) begin
        start     = 1'b1;
        det       = 32'd7;
        intercept = 32'hFFFF_FF00;
        slope     = 32'd42;
        error_det = 1'b1;
        poked     = 1;
      end
      exp_b = vecs[v].exp[8*(6-i) +: 8];
      if (i == stall_at && stalled < stall_len) begin
        out_ready = 1'b0;
        stalled++;
        checkOutput($sformatf("%s/stall%0d_valid", vecs[v].name, stalled), 32'(out_valid), 32'd1);
        checkOutput($sformatf("%s/stall%0d_data", vecs[v].name, stalled), 32'(out_data), 32'(exp_b));
      end else begin
        out_ready = 1'b1;
        if (out_valid) begin
          if (i == 0) checkOutput({vecs[v].name, "/latency"}, 32'(cyc), 32'd2);
          checkOutput($sformatf("%s/byte%0d", vecs[v].name, i), 32'(out_data), 32'(exp_b));
          i++;
        end
      end
    end
    start = 1'b0;
    if (i < 7) checkOutput({vecs[v].name, "/timeout_bytes"}, 32'(i), 32'd7);
    @(negedge clk);
    exp_cnt = exp_cnt + 8'd1;
    checkOutput({vecs[v].name, "/done_pulse"}, 32'(done), 32'd1);
    checkOutput({vecs[v].name, "/frame_cnt"}, 32'(frame_cnt), 32'(exp_cnt));
    checkOutput({vecs[v].name, "/no_extra_byte"}, 32'(out_valid), 32'd0);
    checkOutput({vecs[v].name, "/busy_in_done"}, 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput({vecs[v].name, "/done_clear"}, 32'(done), 32'd0);
    checkOutput({vecs[v].name, "/busy_clear"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{"neg2_1_1",    -32'sd2,   32'd1,    32'd1,    1'b0, 56'h30_22_50_41_90_81_C0};
    vecs[1] = '{"b123_s-7",    32'd40,    32'd123,  -32'sd7,  1'b0, 56'h14_00_59_49_B0_A7_C2};
    vecs[2] = '{"err_det",     32'd0,     32'd55,   32'd5,    1'b1, 56'h10_00_50_40_90_80_C8};
    vecs[3] = '{"det_minneg",  32'h8000_0000, 32'd0, 32'd99,  1'b0, 56'h39_29_50_40_99_89_C4};
    vecs[4] = '{"ovf_mix",     -32'sd100, -32'sd99, 32'd100,  1'b0, 56'h39_29_79_69_99_89_C5};
    vecs[5] = '{"tens_edge",   32'd10,    -32'sd10, 32'd9,    1'b0, 56'h11_00_71_60_90_89_C0};

    rst = 1'b1; start = 1'b0; error_det = 1'b0; out_ready = 1'b1;
    det = '0; intercept = '0; slope = '0;
    exp_cnt = 8'd0;
    repeat (2) @(negedge clk);
    checkOutput("reset/out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset/out_data", 32'(out_data), 32'd0);
    checkOutput("reset/busy", 32'(busy), 32'd0);
    checkOutput("reset/done", 32'(done), 32'd0);
    checkOutput("reset/frame_cnt", 32'(frame_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) send_frame(v, 7, 0, 0);

    $display("[TB] backpressure at byte 3");
    send_frame(0, 3, 5, 0);

    $display("[TB] start while busy");
    send_frame(1, 7, 0, 1);

    $display("[TB] reset mid-frame");
    out_ready = 1'b1;
    applyStimulus(1);
    repeat (5) @(negedge clk);
    checkOutput("midreset/at_byte4", 32'(out_data), 32'hB0);
    #1 rst = 1'b1;
    #1;
    exp_cnt = 8'd0;
    checkOutput("midreset/out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset/out_data", 32'(out_data), 32'd0);
    checkOutput("midreset/busy", 32'(busy), 32'd0);
    checkOutput("midreset/done", 32'(done), 32'd0);
    checkOutput("midreset/frame_cnt", 32'(frame_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("midreset/no_resume_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset/no_resume_busy", 32'(busy), 32'd0);
    send_frame(0, 7, 0, 0);

    $display("[TB] frame counter wrap");
    for (int k = 0; k < 255; k++) send_frame(5, 7, 0, 0);
    checkOutput("wrap/frame_cnt_zero", 32'(frame_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
